// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined N:1 register-select mux:
// clog2 helper for the select width and the main/skid slot count.
package mux_pkg;

  // Slot 0 is the main (output) stage, slot 1 the skid register.
  localparam int SKID_DEPTH = 2;
  localparam int MAIN_SLOT  = 0;
  localparam int SKID_SLOT  = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// Purely combinational N:1 select; any select value at or above
// NUM_IN falls back to the last input.
// Ports: inData (NUM_IN*WIDTH packed), sel (SEL_W), selData (WIDTH).
module mux_sel_comb #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] inData,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        selData
);

  always_comb begin
    selData = inData[(NUM_IN-1)*WIDTH +: WIDTH];
    for (int k = 0; k < NUM_IN - 1; k++) begin
      if (sel == SEL_W'(k)) begin
        selData = inData[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pipe_mux_nto1.sv
// N:1 register-select mux with a registered output, valid/ready
// handshake, 2-entry skid buffer, stall and synchronous flush.
// Ports: Clk, Rst (async high), in_data/in_sel/in_valid/in_ready,
//   flush, out_data/out_valid/out_ready, out_err.
// Macro PIPE_MUX_SEL_ERR_EN: when defined, out_err flags beats whose
//   select was out of range; otherwise out_err is tied to 0.
module pipe_mux_nto1
  import mux_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_err
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
`ifdef PIPE_MUX_SEL_ERR_EN
    logic             err;
`endif
  } beat_t;

  beat_t                 slot [SKID_DEPTH];
  logic [SKID_DEPTH-1:0] valid;
  beat_t                 inBeat;
  logic [WIDTH-1:0]      selData;
  logic                  accept;
  logic                  consume;

  mux_sel_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) uSel (
    .inData  (in_data),
    .sel     (in_sel),
    .selData (selData)
  );

  always_comb begin
    inBeat      = '0;
    inBeat.data = selData;
`ifdef PIPE_MUX_SEL_ERR_EN
    inBeat.err  = int'(in_sel) >= NUM_IN;
`endif
  end

  // Ready depends only on registered state, never on out_ready.
  assign in_ready  = !valid[SKID_SLOT];
  assign accept    = in_valid && in_ready;
  assign consume   = valid[MAIN_SLOT] && out_ready;
  assign out_valid = valid[MAIN_SLOT];
  assign out_data  = slot[MAIN_SLOT].data;
`ifdef PIPE_MUX_SEL_ERR_EN
  assign out_err   = slot[MAIN_SLOT].err;
`else
  assign out_err   = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid           <= '0;
      slot[MAIN_SLOT] <= '0;
      slot[SKID_SLOT] <= '0;
    end else if (flush) begin
      // Data holds; only the valids drop.
      valid <= '0;
    end else if (consume) begin
      if (valid[SKID_SLOT]) begin
        slot[MAIN_SLOT]  <= slot[SKID_SLOT];
        valid[SKID_SLOT] <= 1'b0;
      end else if (accept) begin
        slot[MAIN_SLOT]  <= inBeat;
      end else begin
        valid[MAIN_SLOT] <= 1'b0;
      end
    end else if (!valid[MAIN_SLOT]) begin
      if (accept) begin
        slot[MAIN_SLOT]  <= inBeat;
        valid[MAIN_SLOT] <= 1'b1;
      end
    end else if (accept) begin
      // Stalled output: park the new beat in the skid slot.
      slot[SKID_SLOT]  <= inBeat;
      valid[SKID_SLOT] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_mux_nto1.sv
// Self-checking bench for pipe_mux_nto1 (WIDTH=5, NUM_IN=3) against
// a 2-deep FIFO model with flush; honours PIPE_MUX_SEL_ERR_EN.
module tb_pipe_mux_nto1;

  localparam int WIDTH  = 5;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;
`ifdef PIPE_MUX_SEL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                    Clk = 1'b0;
  logic                    Rst;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             e;
  } exp_t;

  exp_t q[$];

  always #5 Clk = ~Clk;

  pipe_mux_nto1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err)
  );

  function automatic exp_t pick(
    input logic [NUM_IN*WIDTH-1:0] d,
    input logic [SEL_W-1:0]        s
  );
    exp_t r;
    int   idx;
    idx = (int'(s) < NUM_IN) ? int'(s) : NUM_IN - 1;
    r.d = d[idx*WIDTH +: WIDTH];
    r.e = ERR_EN && (int'(s) >= NUM_IN);
    return r;
  endfunction

  function automatic logic [NUM_IN*WIDTH-1:0] pack3(
    input int a, input int b, input int c
  );
    return {WIDTH'(c), WIDTH'(b), WIDTH'(a)};
  endfunction

  // One clock edge; the model is a 2-deep FIFO cleared by flush.
  task automatic tick();
    bit   acc;
    bit   con;
    bit   fl;
    exp_t b;
    acc = in_valid && (q.size() < 2);
    con = (q.size() > 0) && out_ready;
    fl  = flush;
    b   = pick(in_data, in_sel);
    @(posedge Clk);
    if (fl) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    #1;
  endtask

  task automatic test_reset();
    Rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    q.delete();
    repeat (2) @(negedge Clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL reset_out_data got=%0d exp=0", out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_err got=%b exp=0", out_err);
    end
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_latency();
    in_data   = pack3(7, 12, 31);
    in_sel    = 2'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_pre got=%b exp=0", out_valid);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 5'd12) begin
      failures++;
      $display("FAIL latency_beat got=%b/%0d exp=1/12",
               out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_sel_range();
    logic [WIDTH-1:0] expD [4];
    expD[0] = 5'd7;
    expD[1] = 5'd12;
    expD[2] = 5'd31;
    expD[3] = 5'd31;
    in_data   = pack3(7, 12, 31);
    out_ready = 1'b1;
    for (int s = 3; s >= 0; s--) begin
      in_sel   = SEL_W'(s);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== expD[s]) begin
        failures++;
        $display("FAIL sel%0d_data got=%b/%0d exp=1/%0d",
                 s, out_valid, out_data, expD[s]);
      end
      checks++;
      if (out_err !== (ERR_EN && s == 3)) begin
        failures++;
        $display("FAIL sel%0d_err got=%b exp=%b",
                 s, out_err, ERR_EN && s == 3);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] got[$];
    bit               took;
    in_data   = pack3(7, 12, 31);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_sel    = 2'd0;
    tick();
    out_ready = 1'b0;
    in_sel    = 2'd1;
    tick();
    in_sel    = 2'd2;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_data !== 5'd7) begin
        failures++;
        $display("FAIL stall%0d got rdy=%b v=%b d=%0d exp 0/1/7",
                 c, in_ready, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      if (out_valid) got.push_back(out_data);
      took = in_valid && in_ready;
      tick();
      if (took) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 3) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=3", got.size());
    end else begin
      checks++;
      if (got[0] !== 5'd7 || got[1] !== 5'd12 || got[2] !== 5'd31)
      begin
        failures++;
        $display("FAIL bp_order got=%0d,%0d,%0d exp=7,12,31",
                 got[0], got[1], got[2]);
      end
    end
    tick();
  endtask

  task automatic test_flush();
    in_data   = pack3(1, 2, 3);
    in_sel    = 2'd0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_full got=%b exp=0", in_ready);
    end
    in_data = pack3(9, 9, 9);
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_full_clr got v=%b rdy=%b exp 0/1",
               out_valid, in_ready);
    end
    // Main only, accept + consume + flush together.
    in_data = pack3(4, 4, 4);
    tick();
    in_data   = pack3(20, 20, 20);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_acc got v=%b rdy=%b exp 0/1",
               out_valid, in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_ghost%0d got=%b/%0d exp=0",
                 c, out_valid, out_data);
      end
    end
  endtask

  task automatic test_throughput();
    int outs;
    outs      = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = NUM_IN*WIDTH'($urandom);
      in_sel  = SEL_W'($urandom_range(0, 3));
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL tput_rdy%0d got=0 exp=1", i);
      end
      tick();
      if (out_valid) outs++;
      checks++;
      if (q.size() != 1 || out_valid !== 1'b1 ||
          out_data !== q[0].d || out_err !== q[0].e) begin
        failures++;
        $display("FAIL tput_beat%0d got=%b/%0d/%b",
                 i, out_valid, out_data, out_err);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (outs != 20) begin
      failures++;
      $display("FAIL tput_count got=%0d exp=20", outs);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_data   = NUM_IN*WIDTH'($urandom);
      in_sel    = SEL_W'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      checks++;
      if (in_ready !== (q.size() < 2)) begin
        failures++;
        $display("FAIL rnd_rdy%0d got=%b exp=%b",
                 i, in_ready, q.size() < 2);
      end
      tick();
      checks++;
      if (out_valid !== (q.size() > 0)) begin
        failures++;
        $display("FAIL rnd_valid%0d got=%b exp=%b",
                 i, out_valid, q.size() > 0);
      end else if (q.size() > 0) begin
        checks++;
        if (out_data !== q[0].d || out_err !== q[0].e) begin
          failures++;
          $display("FAIL rnd_data%0d got=%0d/%b exp=%0d/%b",
                   i, out_data, out_err, q[0].d, q[0].e);
        end
      end
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    in_data   = pack3(5, 6, 8);
    in_sel    = 2'd2;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    flush     = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_setup got rdy=%b v=%b exp 0/1",
               in_ready, out_valid);
    end
    #2;
    Rst = 1'b1;
    #1;
    q.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_async got v=%b rdy=%b exp 0/1",
               out_valid, in_ready);
    end
    @(negedge Clk);
    Rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_stale%0d got=%b/%0d exp=0",
                 c, out_valid, out_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sel_range();
    test_backpressure();
    test_flush();
    test_throughput();
    test_random();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
